// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the dual-issue instruction buffer.
package inst_buffer_pkg;

    localparam int unsigned IB_DEPTH   = 8;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned CAUSE_W    = 7;
    localparam int unsigned IB_ENTRY_W = PC_W + INST_W + 1 + CAUSE_W;

    // Fetch-side exception cause codes carried through to decode untouched
    localparam logic [CAUSE_W-1:0] EXCEPTION_INT  = 7'h00;
    localparam logic [CAUSE_W-1:0] EXCEPTION_PIF  = 7'h03;
    localparam logic [CAUSE_W-1:0] EXCEPTION_PPI  = 7'h07;
    localparam logic [CAUSE_W-1:0] EXCEPTION_ADEF = 7'h08;
    localparam logic [CAUSE_W-1:0] EXCEPTION_TLBR = 7'h3f;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } ib_entry_t;

endpackage

// File: rtl/ib_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the instruction buffer.
module ib_ptr_ctrl
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = IB_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        enq_valid,
    input  logic [1:0]        deq_accept,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              enq_ready,
    output logic [1:0]        deq_valid,
    output logic              enq_fire_c
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [1:0]        acc;
    logic [1:0]        n_enq;
    logic [1:0]        n_deq;

    // Mask pops against what is actually presented; 2'b10 is not a legal pop
    always_comb begin
        acc         = 2'b00;
        n_enq       = 2'd0;
        n_deq       = 2'd0;
        enq_fire_c  = 1'b0;
        count_next  = count;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;

        if (deq_accept != 2'b10) begin
            acc = deq_accept & deq_valid;
        end
        if (acc[0]) begin
            n_deq = acc[1] ? 2'd2 : 2'd1;
        end

        enq_fire_c = enq_ready && (|enq_valid);
        if (enq_fire_c) begin
            n_enq = (&enq_valid) ? 2'd2 : 2'd1;
        end

        count_next  = count + CNT_W'(n_enq) - CNT_W'(n_deq);
        wr_ptr_next = wr_ptr + ADDR_W'(n_enq);
        rd_ptr_next = rd_ptr + ADDR_W'(n_deq);

        if (flush) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    // Status flags are registered images of the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enq_ready <= 1'b1;
            deq_valid <= 2'b00;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            enq_ready <= (count_next <= CNT_W'(DEPTH - 2));
            deq_valid <= {(count_next >= CNT_W'(2)), (count_next != '0)};
        end
    end

    a_no_hi_only_accept: assert property (@(posedge clk) disable iff (rst)
        deq_accept != 2'b10);

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction FIFO between fetch and decode with show-ahead read.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = IB_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [1:0]         enq_valid,
    input  logic [PC_W-1:0]    enq_pc0,
    input  logic [PC_W-1:0]    enq_pc1,
    input  logic [INST_W-1:0]  enq_inst0,
    input  logic [INST_W-1:0]  enq_inst1,
    input  logic               enq_exc0,
    input  logic               enq_exc1,
    input  logic [CAUSE_W-1:0] enq_cause0,
    input  logic [CAUSE_W-1:0] enq_cause1,
    output logic               enq_ready,
    output logic [1:0]         deq_valid,
    output logic [PC_W-1:0]    deq_pc0,
    output logic [PC_W-1:0]    deq_pc1,
    output logic [INST_W-1:0]  deq_inst0,
    output logic [INST_W-1:0]  deq_inst1,
    output logic               deq_exc0,
    output logic               deq_exc1,
    output logic [CAUSE_W-1:0] deq_cause0,
    output logic [CAUSE_W-1:0] deq_cause1,
    input  logic [1:0]         deq_accept
);

    ib_entry_t         mem [DEPTH];
    ib_entry_t         slot0;
    ib_entry_t         slot1;
    ib_entry_t         wdata0;
    ib_entry_t         head0;
    ib_entry_t         head1;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              enq_fire_c;
    logic              wr_en;

    ib_ptr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .deq_accept (deq_accept),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .enq_fire_c (enq_fire_c)
    );

    // A lone slot1 is compacted into the wr_ptr position so storage never has holes
    always_comb begin
        slot0  = '{pc: enq_pc0, inst: enq_inst0, exc: enq_exc0, cause: enq_cause0};
        slot1  = '{pc: enq_pc1, inst: enq_inst1, exc: enq_exc1, cause: enq_cause1};
        wdata0 = enq_valid[0] ? slot0 : slot1;
        wr_en  = enq_fire_c && !flush;
    end

    // Data storage holds no reset; only control state is cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata0;
            if (&enq_valid) begin
                mem[wr_ptr + ADDR_W'(1)] <= slot1;
            end
        end
    end

    always_comb begin
        head0 = '0;
        head1 = '0;
        if (deq_valid[0]) begin
            head0 = mem[rd_ptr];
        end
        if (deq_valid[1]) begin
            head1 = mem[rd_ptr + ADDR_W'(1)];
        end
        deq_pc0    = head0.pc;
        deq_inst0  = head0.inst;
        deq_exc0   = head0.exc;
        deq_cause0 = head0.cause;
        deq_pc1    = head1.pc;
        deq_inst1  = head1.inst;
        deq_exc1   = head1.exc;
        deq_cause1 = head1.cause;
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [1:0]   enq_valid = 2'b00;
    logic [31:0]  enq_pc0 = '0, enq_pc1 = '0, enq_inst0 = '0, enq_inst1 = '0;
    logic         enq_exc0 = 1'b0, enq_exc1 = 1'b0;
    logic [6:0]   enq_cause0 = '0, enq_cause1 = '0;
    logic         enq_ready;
    logic [1:0]   deq_valid;
    logic [31:0]  deq_pc0, deq_pc1, deq_inst0, deq_inst1;
    logic         deq_exc0, deq_exc1;
    logic [6:0]   deq_cause0, deq_cause1;
    logic [1:0]   deq_accept = 2'b00;

    int checks = 0;
    int errors = 0;
    ib_entry_t mq[$];

    always #5 clk = ~clk;

    inst_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_pc0    (enq_pc0),
        .enq_pc1    (enq_pc1),
        .enq_inst0  (enq_inst0),
        .enq_inst1  (enq_inst1),
        .enq_exc0   (enq_exc0),
        .enq_exc1   (enq_exc1),
        .enq_cause0 (enq_cause0),
        .enq_cause1 (enq_cause1),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .deq_pc0    (deq_pc0),
        .deq_pc1    (deq_pc1),
        .deq_inst0  (deq_inst0),
        .deq_inst1  (deq_inst1),
        .deq_exc0   (deq_exc0),
        .deq_exc1   (deq_exc1),
        .deq_cause0 (deq_cause0),
        .deq_cause1 (deq_cause1),
        .deq_accept (deq_accept)
    );

    function automatic ib_entry_t rand_entry();
        ib_entry_t e;
        e.pc    = $urandom;
        e.inst  = $urandom;
        e.exc   = 1'($urandom);
        e.cause = 7'($urandom);
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input ib_entry_t s0, input ib_entry_t s1,
                         input logic [1:0] acc, input logic fl);
        enq_valid  = v;
        enq_pc0    = s0.pc;   enq_inst0 = s0.inst; enq_exc0 = s0.exc; enq_cause0 = s0.cause;
        enq_pc1    = s1.pc;   enq_inst1 = s1.inst; enq_exc1 = s1.exc; enq_cause1 = s1.cause;
        deq_accept = acc;
        flush      = fl;
    endtask

    // Reference: a FIFO of entries; ready means two free slots before this edge
    task automatic model_edge();
        int sz;
        bit rdy;
        ib_entry_t s0, s1;
        sz  = mq.size();
        rdy = (int'(IB_DEPTH) - sz) >= 2;
        s0  = '{pc: enq_pc0, inst: enq_inst0, exc: enq_exc0, cause: enq_cause0};
        s1  = '{pc: enq_pc1, inst: enq_inst1, exc: enq_exc1, cause: enq_cause1};
        if (flush) begin
            mq.delete();
        end else begin
            if (deq_accept == 2'b01 && sz >= 1) begin
                void'(mq.pop_front());
            end else if (deq_accept == 2'b11) begin
                if (sz >= 1) void'(mq.pop_front());
                if (sz >= 2) void'(mq.pop_front());
            end
            if (rdy) begin
                if (enq_valid[0]) mq.push_back(s0);
                if (enq_valid[1]) mq.push_back(s1);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [146:0] expected();
        logic      rdy;
        logic [1:0] v;
        ib_entry_t e0, e1;
        rdy = (int'(IB_DEPTH) - mq.size()) >= 2;
        v   = {mq.size() >= 2, mq.size() >= 1};
        e0  = (mq.size() >= 1) ? mq[0] : '0;
        e1  = (mq.size() >= 2) ? mq[1] : '0;
        return {rdy, v, e0, e1};
    endfunction

    function automatic logic [146:0] observed();
        return {enq_ready, deq_valid, deq_pc0, deq_inst0, deq_exc0, deq_cause0,
                deq_pc1, deq_inst1, deq_exc1, deq_cause1};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", enq_ready); end
        checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b exp 00", deq_valid); end
        checks++; if (deq_pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc0: got %h exp 0", deq_pc0); end
    endtask

    task automatic test_enq_pair();
        ib_entry_t a, b;
        a = rand_entry(); a.pc = 32'h1c000000;
        b = rand_entry(); b.pc = 32'h1c000004;
        drive(2'b11, a, b, 2'b00, 1'b0);
        step();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL pair_valid: got %b exp 11", deq_valid); end
        checks++; if (deq_pc0 !== 32'h1c000000) begin errors++; $display("FAIL pair_pc0: got %h exp 1c000000", deq_pc0); end
        checks++; if (deq_pc1 !== 32'h1c000004) begin errors++; $display("FAIL pair_pc1: got %h exp 1c000004", deq_pc1); end
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL pair_model: got %h exp %h", observed(), expected()); end
    endtask

    task automatic test_enq_slot1();
        ib_entry_t b;
        drive(2'b00, '0, '0, 2'b00, 1'b1);
        step();
        b = rand_entry(); b.pc = 32'h1c000008;
        drive(2'b10, rand_entry(), b, 2'b00, 1'b0);
        step();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL slot1_valid: got %b exp 01", deq_valid); end
        checks++; if (deq_pc0 !== 32'h1c000008) begin errors++; $display("FAIL slot1_pc0: got %h exp 1c000008", deq_pc0); end
        checks++; if (deq_pc1 !== 32'h0) begin errors++; $display("FAIL slot1_pc1_zero: got %h exp 0", deq_pc1); end
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL slot1_model: got %h exp %h", observed(), expected()); end
    endtask

    task automatic test_full();
        drive(2'b00, '0, '0, 2'b00, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, rand_entry(), rand_entry(), 2'b00, 1'b0);
            step();
        end
        drive(2'b01, rand_entry(), rand_entry(), 2'b00, 1'b0);
        step();
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready7: got %b exp 0", enq_ready); end
        drive(2'b11, rand_entry(), rand_entry(), 2'b00, 1'b0);
        step();
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL full_ignored: got %h exp %h", observed(), expected()); end
        drive(2'b00, '0, '0, 2'b11, 1'b0);
        step();
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_ready5: got %b exp 1", enq_ready); end
        checks++; if (mq.size() != 5 || observed() !== expected()) begin
            errors++; $display("FAIL full_pop_model: got %h exp %h size %0d", observed(), expected(), mq.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, rand_entry(), rand_entry(), 2'b11, 1'b0);
            step();
            checks++; if (deq_valid !== 2'b11 || enq_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_steady[%0d]: got valid %b ready %b exp 11 1", i, deq_valid, enq_ready);
            end
            checks++; if (observed() !== expected()) begin
                errors++; $display("FAIL b2b_order[%0d]: got %h exp %h", i, observed(), expected());
            end
        end
        drive(2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic test_flush();
        drive(2'b00, '0, '0, 2'b00, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, rand_entry(), rand_entry(), 2'b00, 1'b0);
            step();
        end
        drive(2'b11, rand_entry(), rand_entry(), 2'b11, 1'b1);
        step();
        checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b exp 00", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", enq_ready); end
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        step();
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL flush_model: got %h exp %h", observed(), expected()); end
    endtask

    task automatic test_exception();
        ib_entry_t a;
        a = rand_entry(); a.exc = 1'b1; a.cause = EXCEPTION_ADEF;
        drive(2'b01, a, rand_entry(), 2'b00, 1'b0);
        step();
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        checks++; if (deq_exc0 !== 1'b1 || deq_cause0 !== EXCEPTION_ADEF) begin
            errors++; $display("FAIL exc_pass: got exc %b cause %h exp 1 %h", deq_exc0, deq_cause0, EXCEPTION_ADEF);
        end
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL exc_model: got %h exp %h", observed(), expected()); end
    endtask

    task automatic test_random();
        logic [1:0] acc;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       acc = 2'b00;
                1:       acc = 2'b01;
                default: acc = 2'b11;
            endcase
            drive(2'($urandom), rand_entry(), rand_entry(), acc, ($urandom_range(0, 24) == 0));
            step();
            checks++; if (observed() !== expected()) begin
                errors++; $display("FAIL random[%0d]: got %h exp %h", i, observed(), expected());
            end
        end
        drive(2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, rand_entry(), rand_entry(), 2'b00, 1'b0);
            step();
        end
        drive(2'b00, '0, '0, 2'b00, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (deq_valid !== 2'b00 || enq_ready !== 1'b1 || deq_pc0 !== 32'h0) begin
            errors++; $display("FAIL async_rst: got valid %b ready %b pc0 %h exp 00 1 0", deq_valid, enq_ready, deq_pc0);
        end
        mq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b01, rand_entry(), rand_entry(), 2'b00, 1'b0);
        step();
        checks++; if (observed() !== expected()) begin errors++; $display("FAIL async_rst_resume: got %h exp %h", observed(), expected()); end
    endtask

    initial begin
        test_reset();
        test_enq_pair();
        test_enq_slot1();
        test_full();
        test_back_to_back();
        test_flush();
        test_exception();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
